palette_ram_fader: RTL and testbench
====================================

# palette_ram_fader

Runtime-writable colour palette with a two-stage registered read pipeline, a transparency flag and a global brightness fade engine. It sits between a sprite/tile pixel-index generator and the VGA colour output. It generalises the fixed 32-entry 12-bit palette ROM in three ways: parametrised index and colour widths, entries rewritable by the game logic, and fade-to/from-black screen transitions.

## Interface
Parameters:
- INDEX_W, 5: palette index width; depth = 2**INDEX_W entries.
- COLOR_W, 4: bits per colour channel; entry width = 3*COLOR_W, packed {red, green, blue}.
- TRANSP_INDEX, 0: index flagged as transparent.
- FADE_DIV, 1024: clock cycles per brightness step; must be ≥1.

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- index  in  INDEX_W  read index.
- rd_valid  in  1  index is valid this cycle.
- wr_en  in  1  palette write strobe.
- wr_addr  in  INDEX_W  write address.
- wr_data  in  3*COLOR_W  write data {r,g,b}.
- fade_start  in  1  starts a fade; ignored while fade_busy.
- fade_dir  in  1  0 = fade toward black (level 0), 1 = fade toward full (level 2**COLOR_W).
- red, green, blue  out  COLOR_W each  scaled colour.
- out_valid  out  1  red/green/blue/transparent are valid.
- transparent  out  1  the index that produced this output equals TRANSP_INDEX.
- level  out  COLOR_W+1  current brightness, 0..2**COLOR_W.
- fade_busy  out  1  a fade is in progress.
- fade_done  out  1  one-cycle pulse when a fade completes.

## Operation
- Storage: 2**INDEX_W × 3*COLOR_W RAM. Contents are not affected by Reset and are undefined until written. Writes take effect at the clock edge when wr_en=1.
- Read-during-write to the same address in the same cycle returns the old data. A read issued in the next cycle returns the new data.
- Stage 1 registers the RAM word, rd_valid, and (index==TRANSP_INDEX).
- Stage 2 scales each channel: out = (chan * level) >> COLOR_W.
  - The product is 2*COLOR_W+1 bits wide and is truncated after the shift.
  - At level = 2**COLOR_W the output equals chan exactly; at level 0 it is 0.
  - level is sampled in the stage-2 cycle.
- Transparency is reported only; colour is still output for a transparent index.
- Fade FSM states: IDLE, RUN.
  - IDLE: on fade_start, the divider is cleared. If level already equals the target, the FSM stays IDLE and fade_done pulses on the next cycle. Otherwise it goes to RUN.
  - RUN: the divider counts 0..FADE_DIV-1. On the cycle it wraps, level steps by ±1 toward the target. When the step reaches the target, the FSM goes to IDLE and fade_done pulses in that same cycle as the final level update appears.
  - fade_start during RUN is ignored, whatever fade_dir is.
- fade_busy = (state==RUN).

## Timing
- Read latency: exactly 2 cycles. With index/rd_valid presented at edge t, the outputs are valid after edge t+2. Throughput is one read per cycle with no stalls.
- out_valid follows rd_valid delayed by 2. The colour outputs hold their last value when out_valid=0.
- Fade duration from level L to target T: |L−T|·FADE_DIV cycles after the fade_start edge.
- Reset (any cycle, including mid-fade or mid-pipeline) takes effect at the next edge and sets:
  - red=green=blue=0, out_valid=0, transparent=0;
  - level=2**COLOR_W, fade_busy=0, fade_done=0;
  - divider=0, state=IDLE.
  - In-flight reads are discarded.
- Simultaneous write and fade are independent. A level change in the cycle a pixel is in stage 2 applies to that pixel.

## Test plan
- Write index 3 = 0xABC, then read index 3 → 2 cycles later red=0xA, green=0xB, blue=0xC, out_valid=1, transparent=0.
- Read-during-write: write index 7 = 0x123 while reading index 7 (old 0xFFF) → 0xFFF is returned. The next-cycle read of index 7 returns 0x123.
- Read index 0 (TRANSP_INDEX) with entry 0x555 → transparent=1, colour 0x5/0x5/0x5. A back-to-back stream of indices 0,1,2 yields out_valid high for 3 consecutive cycles in order.
- FADE_DIV=4, entry 0xF84, fade_dir=0 → level decrements every 4 cycles, from 16 to 0 over 64 cycles. At level 8 the output is 0x7/0x4/0x2. fade_done pulses once and fade_busy is high for 64 cycles. A fade_start at level 0 with dir=0 gives fade_done next cycle and fade_busy never asserts.
- Assert fade_start with dir=1 mid-fade → ignored and level continues down. Assert Reset at level 5 → level=16, fade_busy=0, out_valid=0 after one edge, with RAM contents intact.

Source files
------------

// File: rtl/palette_ram_fader.sv
// Writable colour palette with 2-stage read pipeline, transparency flag and brightness fade engine.
// Read latency 2 cycles, one read per cycle; no backpressure (outputs hold when out_valid=0).
module palette_ram_fader #(
  parameter int INDEX_W      = 5,
  parameter int COLOR_W      = 4,
  parameter int TRANSP_INDEX = 0,
  parameter int FADE_DIV     = 1024
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [INDEX_W-1:0]     index,
  input  logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [INDEX_W-1:0]     wr_addr,
  input  logic [3*COLOR_W-1:0]   wr_data,
  input  logic                   fade_start,
  input  logic                   fade_dir,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   out_valid,
  output logic                   transparent,
  output logic [COLOR_W:0]       level,
  output logic                   fade_busy,
  output logic                   fade_done
);

  localparam int DEPTH   = 2**INDEX_W;
  localparam int ENTRY_W = 3*COLOR_W;
  localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  localparam logic [COLOR_W:0]     LVL_FULL = {1'b1, {COLOR_W{1'b0}}};
  localparam logic [COLOR_W:0]     LVL_ZERO = '0;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(FADE_DIV - 1);
  localparam logic [INDEX_W-1:0]   TRANSP   = INDEX_W'(TRANSP_INDEX);

  typedef enum logic {IDLE, RUN} fade_state_t;

  // (chan * level) >> COLOR_W; the product fits 2*COLOR_W+1 bits, result truncated
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] chan,
                                               input logic [COLOR_W:0]   lvl);
    logic [2*COLOR_W:0] prod;
    prod  = {{(COLOR_W+1){1'b0}}, chan} * {{COLOR_W{1'b0}}, lvl};
    scale = COLOR_W'(prod >> COLOR_W);
  endfunction

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] s1_word;
  logic               s1_vld;
  logic               s1_transp;

  fade_state_t        state, state_nxt;
  logic [DIV_W-1:0]   div, div_nxt;
  logic [COLOR_W:0]   level_nxt;
  logic [COLOR_W:0]   run_tgt;
  logic               dir_q, dir_nxt;
  logic               done_nxt;

  // Palette storage is deliberately untouched by Reset.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read and write share an edge, so a same-address read sees the old word.
  always_ff @(posedge Clk) begin
    s1_word <= mem[index];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_vld    <= 1'b0;
      s1_transp <= 1'b0;
    end else begin
      s1_vld    <= rd_valid;
      s1_transp <= (index == TRANSP);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      out_valid   <= 1'b0;
      transparent <= 1'b0;
    end else begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        red         <= scale(s1_word[3*COLOR_W-1:2*COLOR_W], level);
        green       <= scale(s1_word[2*COLOR_W-1:COLOR_W], level);
        blue        <= scale(s1_word[COLOR_W-1:0], level);
        transparent <= s1_transp;
      end
    end
  end

  assign run_tgt   = dir_q ? LVL_FULL : LVL_ZERO;
  assign fade_busy = (state == RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      div       <= '0;
      level     <= LVL_FULL;
      dir_q     <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      div       <= div_nxt;
      level     <= level_nxt;
      dir_q     <= dir_nxt;
      fade_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    level_nxt = level;
    dir_nxt   = dir_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (fade_start) begin
          div_nxt = '0;
          dir_nxt = fade_dir;
          if (level == (fade_dir ? LVL_FULL : LVL_ZERO)) done_nxt  = 1'b1;
          else                                           state_nxt = RUN;
        end
      end
      RUN: begin
        // fade_start is ignored here; the latched direction drives the fade.
        if (div == DIV_LAST) begin
          div_nxt   = '0;
          level_nxt = dir_q ? level + 1'b1 : level - 1'b1;
          if (level_nxt == run_tgt) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_palette_ram_fader.sv
// Scoreboarded bench for palette_ram_fader: reads, read-during-write, transparency, fades, reset.
module tb_palette_ram_fader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  index, wr_addr;
  logic        rd_valid, wr_en, fade_start, fade_dir;
  logic [11:0] wr_data;
  logic [3:0]  red, green, blue;
  logic        out_valid, transparent, fade_busy, fade_done;
  logic [4:0]  level;

  always #5 Clk = ~Clk;

  palette_ram_fader #(.INDEX_W(5), .COLOR_W(4), .TRANSP_INDEX(0), .FADE_DIV(4)) dut (
    .Clk(Clk), .Reset(Reset), .index(index), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fade_start(fade_start), .fade_dir(fade_dir),
    .red(red), .green(green), .blue(blue), .out_valid(out_valid),
    .transparent(transparent), .level(level), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  typedef struct {
    logic [3:0] r, g, b;
    logic       t;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Expected pixel for a read driven now: visible two edges later.
  task automatic push(input logic [11:0] rgb, input logic t);
    exp_t e;
    e.r = rgb[11:8]; e.g = rgb[7:4]; e.b = rgb[3:0]; e.t = t;
    e.due = cyc + 2;
    q.push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("out_valid", out_valid, 1);
        check("red", red, e.r);
        check("green", green, e.g);
        check("blue", blue, e.b);
        check("transparent", transparent, e.t);
      end else begin
        check("idle_out_valid", out_valid, 0);
      end
    end
  end

  initial begin
    Reset = 1'b1; index = '0; rd_valid = 1'b0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; fade_start = 1'b0; fade_dir = 1'b0;
    tick(); tick();
    check("rst_red", red, 0);
    check("rst_green", green, 0);
    check("rst_blue", blue, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_transparent", transparent, 0);
    check("rst_level", level, 16);
    check("rst_busy", fade_busy, 0);
    check("rst_done", fade_done, 0);
    Reset = 1'b0;
    mon_en = 1'b1;

    // basic write then read
    wr(5'd3, 12'hABC);
    index = 5'd3; rd_valid = 1'b1; push(12'hABC, 1'b0);
    tick(); rd_valid = 1'b0;
    tick(); tick();

    // read-during-write returns old word, next read the new one
    wr(5'd7, 12'hFFF);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 12'h123;
    index = 5'd7; rd_valid = 1'b1; push(12'hFFF, 1'b0);
    tick(); wr_en = 1'b0;
    push(12'h123, 1'b0);
    tick(); rd_valid = 1'b0;
    tick(); tick();

    // transparency and back-to-back stream
    wr(5'd0, 12'h555);
    wr(5'd1, 12'h0F0);
    wr(5'd2, 12'h00F);
    for (int i = 0; i < 3; i++) begin
      index = 5'(i); rd_valid = 1'b1;
      push((i == 0) ? 12'h555 : (i == 1) ? 12'h0F0 : 12'h00F, i == 0);
      tick();
    end
    rd_valid = 1'b0;
    tick(); tick();

    // fade to black, FADE_DIV=4: one step every 4 cycles, 64 cycles total
    wr(5'd5, 12'hF84);
    fade_dir = 1'b0; fade_start = 1'b1;
    tick(); fade_start = 1'b0;
    check("fade_n0_level", level, 16);
    check("fade_n0_busy", fade_busy, 1);
    for (int n = 1; n <= 66; n++) begin
      tick();
      fade_start = 1'b0; rd_valid = 1'b0;
      check("fade_level", level, 32'(16 - ((n < 64 ? n : 64) / 4)));
      check("fade_busy", fade_busy, n < 64);
      check("fade_done", fade_done, n == 64);
      if (n == 20) begin
        fade_start = 1'b1; fade_dir = 1'b1;
      end
      if (n == 32) begin
        index = 5'd5; rd_valid = 1'b1; push(12'h742, 1'b0);
      end
    end

    // start at target: done next cycle, never busy
    fade_dir = 1'b0; fade_start = 1'b1;
    tick(); fade_start = 1'b0;
    check("at_tgt_done", fade_done, 1);
    check("at_tgt_busy", fade_busy, 0);
    tick();
    check("at_tgt_done_clr", fade_done, 0);
    check("at_tgt_busy2", fade_busy, 0);
    check("at_tgt_level", level, 0);

    // fade up to level 5, then reset with a read in flight
    fade_dir = 1'b1; fade_start = 1'b1;
    tick(); fade_start = 1'b0;
    for (int n = 1; n <= 20; n++) tick();
    check("up_level5", level, 5);
    check("up_busy", fade_busy, 1);
    index = 5'd3; rd_valid = 1'b1; Reset = 1'b1;
    tick(); Reset = 1'b0; rd_valid = 1'b0;
    check("mid_rst_level", level, 16);
    check("mid_rst_busy", fade_busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_red", red, 0);
    tick(); tick();

    // RAM survives reset
    index = 5'd3; rd_valid = 1'b1; push(12'hABC, 1'b0);
    tick();
    index = 5'd5; push(12'hF84, 1'b0);
    tick(); rd_valid = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    check("sb_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
